hazard_ctrl: RTL and testbench

Pipeline hazard and ISA-mode sequencing controller for the combined ARM/RISC-V five-stage core. It generates stall, flush and forwarding controls for the F/D/E stage registers. It sequences the pipeline drain needed when an ISA-switch instruction changes decode mode. It owns the architectural ARM/RISC-V mode bit consumed by fetch and the D-stage mode flop, and keeps two free-running performance counters.

---
 rtl/hazard_ctrl_pkg.sv | 23 ++
 rtl/hazard_ctrl_fwd.sv | 42 ++++
 rtl/hazard_ctrl.sv | 134 +++++++++++++
 tb/tb_hazard_ctrl.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the hazard/ISA-mode controller: FSM states,
// forward-select encodings and the mode-dependent register-match rule.
package hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    SWITCH = 2'd2
  } state_e;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

  localparam logic [4:0] REG_ZERO   = 5'd0;
  localparam logic [4:0] REG_PC_ARM = 5'd15;

  // x0 is hardwired in RISC-V; r15 reads as PC+8 in ARM, so neither can carry a hazard.
  function automatic logic reg_valid(input logic [4:0] r, input logic arm);
    return arm ? (r != REG_PC_ARM) : (r != REG_ZERO);
  endfunction

endpackage

// File: rtl/hazard_ctrl_fwd.sv
// Combinational operand forwarding and load-use detection, aware of the
// current decode mode for the non-matching register index.
module hazard_fwd
  import hazard_ctrl_pkg::*;
(
  input  logic       arm_mode,
  input  logic [4:0] Rs1D,
  input  logic [4:0] Rs2D,
  input  logic [4:0] Rs1E,
  input  logic [4:0] Rs2E,
  input  logic [4:0] RdE,
  input  logic [4:0] RdM,
  input  logic [4:0] RdW,
  input  logic       RegWriteM,
  input  logic       RegWriteW,
  input  logic       ResultSrcE0,
  output logic [1:0] ForwardAE,
  output logic [1:0] ForwardBE,
  output logic       lw_stall
);

  // M is younger than W, so its result wins when both match.
  function automatic logic [1:0] fwd_sel(input logic [4:0] rs, input logic [4:0] rd_m,
                                         input logic [4:0] rd_w, input logic we_m,
                                         input logic we_w, input logic arm);
    logic [1:0] sel;
    sel = FWD_RF;
    if (reg_valid(rs, arm)) begin
      if (we_m && (rd_m == rs))      sel = FWD_M;
      else if (we_w && (rd_w == rs)) sel = FWD_W;
    end
    return sel;
  endfunction

  always_comb begin
    ForwardAE = fwd_sel(Rs1E, RdM, RdW, RegWriteM, RegWriteW, arm_mode);
    ForwardBE = fwd_sel(Rs2E, RdM, RdW, RegWriteM, RegWriteW, arm_mode);
    lw_stall  = ResultSrcE0 && reg_valid(RdE, arm_mode) &&
                ((RdE == Rs1D) || (RdE == Rs2D));
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller with ISA-switch drain sequencing, the architectural
// ARM/RISC-V mode bit and stall/flush performance counters.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int       DRAIN_CYCLES = 3,
  parameter bit       INIT_ARM     = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  Rs1D,
  input  logic [4:0]  Rs2D,
  input  logic [4:0]  Rs1E,
  input  logic [4:0]  Rs2E,
  input  logic [4:0]  RdE,
  input  logic [4:0]  RdM,
  input  logic [4:0]  RdW,
  input  logic        RegWriteM,
  input  logic        RegWriteW,
  input  logic        ResultSrcE0,
  input  logic        PCSrcE,
  input  logic        SwitchReqD,
  input  logic        TargetArmD,
  output logic        StallF,
  output logic        StallD,
  output logic        FlushD,
  output logic        FlushE,
  output logic [1:0]  ForwardAE,
  output logic [1:0]  ForwardBE,
  output logic        ArmMode,
  output logic        Switching,
  output logic [31:0] StallCount,
  output logic [31:0] FlushCount
);

  localparam int CNT_W = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);

  state_e             state, state_nx;
  logic [CNT_W-1:0]   cnt, cnt_nx;
  logic               arm_mode_q;
  logic               target_q;
  logic               lw_stall;
  logic               accept;
  logic               drain_done;
  logic [31:0]        stall_count;
  logic [31:0]        flush_count;

  hazard_fwd u_fwd (
    .arm_mode    (arm_mode_q),
    .Rs1D        (Rs1D),
    .Rs2D        (Rs2D),
    .Rs1E        (Rs1E),
    .Rs2E        (Rs2E),
    .RdE         (RdE),
    .RdM         (RdM),
    .RdW         (RdW),
    .RegWriteM   (RegWriteM),
    .RegWriteW   (RegWriteW),
    .ResultSrcE0 (ResultSrcE0),
    .ForwardAE   (ForwardAE),
    .ForwardBE   (ForwardBE),
    .lw_stall    (lw_stall)
  );

  assign drain_done = (state == DRAIN) && (cnt == CNT_W'(1));

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    accept   = 1'b0;
    StallF   = 1'b0;
    StallD   = 1'b0;
    FlushD   = 1'b0;
    FlushE   = 1'b0;
    case (state)
      RUN: begin
        StallF = lw_stall;
        StallD = lw_stall;
        FlushD = PCSrcE;
        FlushE = lw_stall | PCSrcE;
        // A switch seen alongside a taken branch is on the wrong path.
        if (SwitchReqD && !lw_stall && !PCSrcE) begin
          accept   = 1'b1;
          StallF   = 1'b1;
          FlushD   = 1'b1;
          cnt_nx   = CNT_W'(DRAIN_CYCLES);
          state_nx = DRAIN;
        end
      end
      DRAIN: begin
        StallF = 1'b1;
        FlushD = 1'b1;
        cnt_nx = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) state_nx = SWITCH;
      end
      SWITCH: begin
        StallF   = 1'b1;
        FlushD   = 1'b1;
        state_nx = RUN;
      end
      default: state_nx = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= RUN;
      cnt        <= '0;
      arm_mode_q <= INIT_ARM;
      target_q   <= INIT_ARM;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (accept)     target_q   <= TargetArmD;
      if (drain_done) arm_mode_q <= target_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      stall_count <= stall_count + 32'(StallF);
      flush_count <= flush_count + 32'(FlushD | FlushE);
    end
  end

  assign ArmMode    = arm_mode_q;
  assign Switching  = (state != RUN);
  assign StallCount = stall_count;
  assign FlushCount = flush_count;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: forwarding, load-use, ISA switch sequence,
// wrong-path switch, reset mid-drain and counter wrap.
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [4:0]  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic        RegWriteM, RegWriteW, ResultSrcE0, PCSrcE, SwitchReqD, TargetArmD;
  logic        StallF, StallD, FlushD, FlushE, ArmMode, Switching;
  logic [1:0]  ForwardAE, ForwardBE;
  logic [31:0] StallCount, FlushCount;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.DRAIN_CYCLES(3), .INIT_ARM(1'b0)) dut (
    .clk(clk), .rst(rst),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
    .RdE(RdE), .RdM(RdM), .RdW(RdW),
    .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .ResultSrcE0(ResultSrcE0),
    .PCSrcE(PCSrcE), .SwitchReqD(SwitchReqD), .TargetArmD(TargetArmD),
    .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .ArmMode(ArmMode), .Switching(Switching),
    .StallCount(StallCount), .FlushCount(FlushCount)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
    RegWriteM = 0; RegWriteW = 0; ResultSrcE0 = 0; PCSrcE = 0;
    SwitchReqD = 0; TargetArmD = 0;
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    idle();
    step(); step();
    #1;
    check("rst_stallf", 32'(StallF), 0);
    check("rst_flushd", 32'(FlushD), 0);
    check("rst_switching", 32'(Switching), 0);
    check("rst_armmode", 32'(ArmMode), 0);
    check("rst_stallcnt", StallCount, 0);
    check("rst_flushcnt", FlushCount, 0);
    step(); rst = 1'b1;
    #1;
    check("idle_flushe", 32'(FlushE), 0);
    check("idle_fwda", 32'(ForwardAE), 0);

    // RISC-V forwarding
    step(); RegWriteM = 1; RdM = 5; Rs1E = 5; #1;
    check("rv_fwd_m", 32'(ForwardAE), 32'h2);
    RegWriteW = 1; RdW = 5; #1;
    check("rv_fwd_m_over_w", 32'(ForwardAE), 32'h2);
    RegWriteM = 0; Rs2E = 5; #1;
    check("rv_fwd_b_w", 32'(ForwardBE), 32'h1);
    RegWriteM = 1; RdM = 0; RdW = 0; Rs1E = 0; Rs2E = 0; #1;
    check("rv_x0_a", 32'(ForwardAE), 0);
    check("rv_x0_b", 32'(ForwardBE), 0);
    idle();

    // Load-use, one cycle
    step(); ResultSrcE0 = 1; RdE = 7; Rs2D = 7; #1;
    check("lu_stallf", 32'(StallF), 1);
    check("lu_stalld", 32'(StallD), 1);
    check("lu_flushe", 32'(FlushE), 1);
    check("lu_flushd", 32'(FlushD), 0);
    step(); idle(); #1;
    check("lu_end_stallf", 32'(StallF), 0);
    check("lu_stallcnt", StallCount, 1);
    check("lu_flushcnt", FlushCount, 1);

    // Switch RISC-V -> ARM
    step(); SwitchReqD = 1; TargetArmD = 1; #1;
    check("sw_acc_stallf", 32'(StallF), 1);
    check("sw_acc_flushd", 32'(FlushD), 1);
    check("sw_acc_switching", 32'(Switching), 0);
    step(); SwitchReqD = 0; TargetArmD = 0; PCSrcE = 1; #1;
    check("sw_d1_switching", 32'(Switching), 1);
    check("sw_d1_flushe_ignores_pcsrc", 32'(FlushE), 0);
    check("sw_d1_stalld", 32'(StallD), 0);
    check("sw_d1_arm", 32'(ArmMode), 0);
    step(); PCSrcE = 0; #1;
    check("sw_d2_stallf", 32'(StallF), 1);
    check("sw_d2_arm", 32'(ArmMode), 0);
    step(); #1;
    check("sw_d3_switching", 32'(Switching), 1);
    check("sw_d3_arm", 32'(ArmMode), 0);
    step(); #1;
    check("sw_s_switching", 32'(Switching), 1);
    check("sw_s_flushd", 32'(FlushD), 1);
    check("sw_s_arm", 32'(ArmMode), 1);
    step(); #1;
    check("sw_run_switching", 32'(Switching), 0);
    check("sw_run_stallf", 32'(StallF), 0);
    check("sw_run_arm", 32'(ArmMode), 1);
    check("sw_stallcnt", StallCount, 6);
    check("sw_flushcnt", FlushCount, 6);

    // ARM-mode forwarding: r0 valid, r15 never matches
    RegWriteM = 1; RdM = 0; Rs1E = 0; #1;
    check("arm_fwd_r0", 32'(ForwardAE), 32'h2);
    RdM = 15; Rs1E = 15; RegWriteW = 1; RdW = 15; #1;
    check("arm_fwd_r15", 32'(ForwardAE), 0);
    idle();

    // Wrong-path switch with taken branch
    step(); SwitchReqD = 1; TargetArmD = 0; PCSrcE = 1; #1;
    check("wp_flushd", 32'(FlushD), 1);
    check("wp_flushe", 32'(FlushE), 1);
    check("wp_stallf", 32'(StallF), 0);
    step(); idle(); #1;
    check("wp_switching", 32'(Switching), 0);
    check("wp_arm", 32'(ArmMode), 1);
    check("wp_flushcnt", FlushCount, 7);

    // Load-use delays acceptance, then reset two cycles into DRAIN
    step(); ResultSrcE0 = 1; RdE = 7; Rs1D = 7; SwitchReqD = 1; TargetArmD = 0; #1;
    check("lud_stalld", 32'(StallD), 1);
    check("lud_flushd", 32'(FlushD), 0);
    step(); ResultSrcE0 = 0; RdE = 0; Rs1D = 0; #1;
    check("lud_acc_flushd", 32'(FlushD), 1);
    check("lud_acc_stalld", 32'(StallD), 0);
    check("lud_acc_switching", 32'(Switching), 0);
    step(); SwitchReqD = 0; #1;
    check("lud_d1_switching", 32'(Switching), 1);
    step(); rst = 1'b0; #1;
    check("rstd_switching", 32'(Switching), 0);
    check("rstd_arm", 32'(ArmMode), 0);
    check("rstd_stallcnt", StallCount, 0);
    check("rstd_flushcnt", FlushCount, 0);
    step(); rst = 1'b1;

    // Same-mode switch still runs the full sequence
    step(); SwitchReqD = 1; TargetArmD = 0; #1;
    check("sm_acc_stallf", 32'(StallF), 1);
    for (int i = 1; i <= 4; i++) begin
      step(); SwitchReqD = 0; #1;
      check($sformatf("sm_c%0d_switching", i), 32'(Switching), 1);
      check($sformatf("sm_c%0d_arm", i), 32'(ArmMode), 0);
    end
    step(); #1;
    check("sm_end_switching", 32'(Switching), 0);
    check("sm_stallcnt", StallCount, 5);
    check("sm_flushcnt", FlushCount, 5);

    // StallCount wrap
    step(); ResultSrcE0 = 1; RdE = 7; Rs2D = 7;
    force dut.stall_count = 32'hFFFF_FFFF;
    #1 release dut.stall_count;
    #1;
    check("wrap_pre", StallCount, 32'hFFFF_FFFF);
    step(); idle(); #1;
    check("wrap_stallcnt", StallCount, 0);
    check("wrap_flushcnt", FlushCount, 6);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
